// File: rtl/period_meter.sv
// period_meter: measures the period of an asynchronous square wave in CLK cycles.
// The result is an average over 2^AVG_SHIFT_BITS input periods. Windows run
// back to back, and the block reports loss of signal when a window overflows.
// The result uses the same fixed-point period format as the period-driven NCO:
// PERIOD_INT_PART integer bits and PERIOD_FRAC_PART fraction bits.
//
// Ports:
//   CLK          single clock
//   RESET        synchronous, active-high reset
//   CE           clock enable; while low, all state (synchronizer included) holds
//   SIGNAL_IN    asynchronous oscillator input; only rising edges are counted
//   PERIOD_OUT   last measured period (fixed point); all ones after an overflow
//   PERIOD_VALID one-CE-cycle pulse each time PERIOD_OUT is written
//   NO_SIGNAL    high while no valid measurement stands
//
// AVG_SHIFT_BITS must stay within 0..PERIOD_FRAC_PART.
module period_meter #(
  parameter int unsigned PERIOD_INT_PART  = 10,
  parameter int unsigned PERIOD_FRAC_PART = 20,
  parameter int unsigned AVG_SHIFT_BITS   = 8
) (
  input  logic                                        CLK,
  input  logic                                        RESET,
  input  logic                                        CE,
  input  logic                                        SIGNAL_IN,
  output logic [PERIOD_INT_PART+PERIOD_FRAC_PART-1:0] PERIOD_OUT,
  output logic                                        PERIOD_VALID,
  output logic                                        NO_SIGNAL
);

  localparam int unsigned PW    = PERIOD_INT_PART + PERIOD_FRAC_PART;
  localparam int unsigned CNT_W = PERIOD_INT_PART + AVG_SHIFT_BITS;
  // edge_cnt keeps one bit when AVG_SHIFT_BITS is 0; that bit then stays at zero.
  localparam int unsigned EC_W  = (AVG_SHIFT_BITS == 0) ? 1 : AVG_SHIFT_BITS;
  // The count left-aligns into the fraction field.
  localparam int unsigned PAD_W = PERIOD_FRAC_PART - AVG_SHIFT_BITS;

  localparam logic [EC_W-1:0]  EDGE_LAST = EC_W'((64'd1 << AVG_SHIFT_BITS) - 64'd1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    MEASURE   = 1'b1
  } state_t;

  state_t             state;
  logic               sync1;
  logic               sync2;
  logic               prev;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [EC_W-1:0]    edge_cnt;

  logic               rise_c;
  logic               close_c;
  logic               ovf_c;

  // Rising edge of the synchronized input.
  assign rise_c  = sync2 & ~prev;
  // This edge completes 2^AVG_SHIFT_BITS periods.
  assign close_c = rise_c && (edge_cnt == EDGE_LAST);
  // The window has run out of counter range.
  assign ovf_c   = (cyc_cnt == CNT_MAX);

  // Synchronizer, window counters and result registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= WAIT_EDGE;
      sync1        <= 1'b0;
      sync2        <= 1'b0;
      prev         <= 1'b0;
      cyc_cnt      <= '0;
      edge_cnt     <= '0;
      PERIOD_OUT   <= '0;
      PERIOD_VALID <= 1'b0;
      NO_SIGNAL    <= 1'b1;
    end else if (CE) begin
      sync1        <= SIGNAL_IN;
      sync2        <= sync1;
      prev         <= sync2;
      PERIOD_VALID <= 1'b0;

      case (state)
        WAIT_EDGE: begin
          // The first edge opens a window; the count includes this cycle.
          if (rise_c) begin
            cyc_cnt  <= CNT_W'(1);
            edge_cnt <= '0;
            state    <= MEASURE;
          end
        end

        MEASURE: begin
          if (close_c) begin
            // A closure wins over an overflow in the same cycle. The
            // closing edge also opens the next window, so windows have no gaps.
            PERIOD_OUT   <= PW'(cyc_cnt) << PAD_W;
            PERIOD_VALID <= 1'b1;
            NO_SIGNAL    <= 1'b0;
            cyc_cnt      <= CNT_W'(1);
            edge_cnt     <= '0;
          end else if (ovf_c) begin
            PERIOD_OUT   <= '1;
            PERIOD_VALID <= 1'b1;
            NO_SIGNAL    <= 1'b1;
            state        <= WAIT_EDGE;
          end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (rise_c) begin
              edge_cnt <= edge_cnt + EC_W'(1);
            end
          end
        end

        default: state <= WAIT_EDGE;
      endcase
    end
  end

endmodule
